// File: rtl/memory_bank_if.sv
// Request/response bus between the load/store unit (master) and a memory bank (slave).
interface memory_bank_if #(
    parameter int BYTES  = 4,
    parameter int ADDR_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [BYTES-1:0]     req_wstrb;
    logic [8*BYTES-1:0]   req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [8*BYTES-1:0]   rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wstrb, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wstrb, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/memory_bank.sv
// Word-addressed RAM bank with byte strobes, one-cycle valid/ready responses,
// out-of-range error reporting and a post-reset clear sweep.
module memory_bank #(
    parameter int WORDS  = 64,
    parameter int BYTES  = 4,
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    memory_bank_if.slave bus,
    output logic         busy
);
    localparam int                DW      = 8 * BYTES;
    localparam int                IDX_W   = $clog2(WORDS);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(WORDS - 1);
    localparam logic [31:0]       WORDS_U = WORDS;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] clr_ptr;
    logic [DW-1:0]    mem [WORDS];
    logic             req_ready;

    logic             accept_p0;
    logic             in_range_p0;
    logic [IDX_W-1:0] idx_p0;

    logic             rsp_valid_p1;
    logic             rsp_err_p1;
    logic [DW-1:0]    rsp_rdata_p1;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]    old_w,
                                                  input logic [DW-1:0]    new_w,
                                                  input logic [BYTES-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BYTES; i++)
            if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR && clr_ptr != LAST) clr_ptr <= clr_ptr + IDX_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == LAST) state_nxt = RUN;
    end

    always_comb begin
        busy      = (state == CLEAR);
        req_ready = (state == RUN) && (!rsp_valid_p1 || bus.rsp_ready);
    end

    // p0: request decode; nothing is accepted on a reset edge
    assign in_range_p0   = 32'(bus.req_addr) < WORDS_U;
    assign idx_p0        = bus.req_addr[IDX_W-1:0];
    assign accept_p0     = bus.req_valid && req_ready && !reset;
    assign bus.req_ready = req_ready;

    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR)
            mem[clr_ptr] <= '0;
        else if (accept_p0 && bus.req_write && in_range_p0)
            mem[idx_p0] <= merge_bytes(mem[idx_p0], bus.req_wdata, bus.req_wstrb);
    end

    // p1: response register, held under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_p1 <= 1'b0;
            rsp_err_p1   <= 1'b0;
            rsp_rdata_p1 <= '0;
        end else if (accept_p0) begin
            rsp_valid_p1 <= 1'b1;
            rsp_err_p1   <= !in_range_p0;
            rsp_rdata_p1 <= (in_range_p0 && !bus.req_write) ? mem[idx_p0] : '0;
        end else if (bus.rsp_ready) begin
            rsp_valid_p1 <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_p1;
    assign bus.rsp_err   = rsp_err_p1;
    assign bus.rsp_rdata = rsp_rdata_p1;
endmodule

// File: tb/tb_memory_bank.sv
// Directed self-checking bench for memory_bank (64 words x 32 bits).
module tb_memory_bank;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_mem [64];

    memory_bank_if #(.BYTES(4), .ADDR_W(8)) bus ();

    memory_bank #(.WORDS(64), .BYTES(4), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [7:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic rv, output logic [31:0] rd,
                        output logic re);
        int tmo;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wstrb = s;
        bus.req_wdata = d;
        #1;
        tmo = 0;
        while (!bus.req_ready && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        check("accept_wait", tmo, 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rv = bus.rsp_valid;
        rd = bus.rsp_rdata;
        re = bus.rsp_err;
    endtask

    task automatic count_busy(input string tag);
        int cnt;
        int rdy_hi;
        cnt = 0;
        rdy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (bus.req_ready) rdy_hi++;
        end
        check({tag, "_busy_cycles"}, cnt, 64);
        check({tag, "_ready_while_busy"}, rdy_hi, 0);
    endtask

    initial begin
        logic        rv;
        logic        re;
        logic [31:0] rd;
        logic [31:0] wd;
        logic [7:0]  a;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1);
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_rsp_rdata", bus.rsp_rdata, 0);
        reset = 1'b0;
        count_busy("init");
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;

        // Cleared words read back as zero
        xact(1'b0, 8'd0, 4'h0, 32'h0, rv, rd, re);
        check("rd0_valid", rv, 1); check("rd0_data", rd, 32'h0); check("rd0_err", re, 0);
        xact(1'b0, 8'd37, 4'h0, 32'h0, rv, rd, re);
        check("rd37_valid", rv, 1); check("rd37_data", rd, 32'h0); check("rd37_err", re, 0);
        xact(1'b0, 8'd63, 4'h0, 32'h0, rv, rd, re);
        check("rd63_valid", rv, 1); check("rd63_data", rd, 32'h0); check("rd63_err", re, 0);

        // Byte strobes
        xact(1'b1, 8'd3, 4'hF, 32'h11223344, rv, rd, re);
        check("wr3_valid", rv, 1); check("wr3_rdata", rd, 32'h0); check("wr3_err", re, 0);
        xact(1'b1, 8'd3, 4'b0101, 32'hAABBCCDD, rv, rd, re);
        check("wr3p_rdata", rd, 32'h0);
        xact(1'b0, 8'd3, 4'h0, 32'h0, rv, rd, re);
        check("rd3_merged", rd, 32'h11BB33DD);
        exp_mem[3] = 32'h11BB33DD;

        // Backpressure
        xact(1'b1, 8'd5, 4'hF, 32'hCAFEF00D, rv, rd, re);
        exp_mem[5] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("retire_idle", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;
        xact(1'b0, 8'd5, 4'h0, 32'h0, rv, rd, re);
        check("bp_first_valid", rv, 1);
        check("bp_first_data", rd, 32'hCAFEF00D);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'd5;
        bus.req_wstrb = 4'hF;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_data", bus.rsp_rdata, 32'hCAFEF00D);
            check("bp_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_retire", bus.rsp_valid, 0);

        // Out-of-range addresses
        xact(1'b0, 8'd64, 4'h0, 32'h0, rv, rd, re);
        check("oor_rd_valid", rv, 1); check("oor_rd_err", re, 1); check("oor_rd_data", rd, 32'h0);
        xact(1'b1, 8'd200, 4'hF, 32'hFFFFFFFF, rv, rd, re);
        check("oor_wr_err", re, 1); check("oor_wr_data", rd, 32'h0);
        xact(1'b0, 8'd10, 4'h0, 32'h0, rv, rd, re);
        check("inrange_err_clear", re, 0);
        for (int i = 0; i < 64; i++) begin
            xact(1'b0, 8'(i), 4'h0, 32'h0, rv, rd, re);
            check($sformatf("sweep_w%0d", i), rd, exp_mem[i]);
        end

        // Back-to-back streaming of write/read pairs
        for (int k = 0; k < 32; k++) begin
            a  = 8'(k / 2);
            wd = 32'h12340000 + 32'(a) * 32'h00011111;
            bus.req_valid = 1'b1;
            bus.req_write = (k % 2 == 0);
            bus.req_addr  = a;
            bus.req_wstrb = 4'hF;
            bus.req_wdata = wd;
            @(posedge clk);
            #1;
            check("stream_valid", bus.rsp_valid, 1);
            check($sformatf("stream_data_%0d", k), bus.rsp_rdata, (k % 2 == 0) ? 32'h0 : wd);
            if (k % 2 == 0) exp_mem[a] = wd;
        end
        bus.req_valid = 1'b0;
        xact(1'b0, 8'd7, 4'h0, 32'h0, rv, rd, re);
        check("stream_rd7", rd, 32'h12340000 + 32'd7 * 32'h00011111);

        // Reset in the middle of the clear sweep
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midsweep_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy("midsweep");
        xact(1'b0, 8'd7, 4'h0, 32'h0, rv, rd, re);
        check("post_sweep_rd7", rd, 32'h0);
        xact(1'b0, 8'd40, 4'h0, 32'h0, rv, rd, re);
        check("post_sweep_rd40", rd, 32'h0);

        // Reset with a response pending
        xact(1'b1, 8'd9, 4'hF, 32'h12345678, rv, rd, re);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        xact(1'b0, 8'd9, 4'h0, 32'h0, rv, rd, re);
        check("pend_valid", rv, 1);
        check("pend_data", rd, 32'h12345678);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("pend_rst_valid", bus.rsp_valid, 0);
        check("pend_rst_data", bus.rsp_rdata, 32'h0);
        check("pend_rst_err", bus.rsp_err, 0);
        check("pend_rst_busy", busy, 1);
        check("pend_rst_ready", bus.req_ready, 0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        count_busy("pending");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
